// File: rtl/mem_trace_buffer.sv
// mem_trace_buffer: passive observer of a picorv32 native memory bus.
// Transfers that pass the class enable and address window filters are
// stored with a free-running timestamp in a circular buffer. The buffer
// is read out first-word-fall-through, oldest entry first. When full,
// new entries are either dropped (WRAP=0) or replace the oldest (WRAP=1).
module mem_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int TS_W  = 16,
  parameter int WRAP  = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_valid,
  input  logic                     mem_ready,
  input  logic                     mem_instr,
  input  logic [31:0]              mem_addr,
  input  logic [31:0]              mem_wdata,
  input  logic [31:0]              mem_rdata,
  input  logic [3:0]               mem_wstrb,
  input  logic [2:0]               cfg_en,
  input  logic [31:0]              cfg_addr_lo,
  input  logic [31:0]              cfg_addr_hi,
  input  logic                     cfg_clear,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [1:0]               rd_kind,
  output logic [31:0]              rd_addr,
  output logic [31:0]              rd_data,
  output logic [3:0]               rd_wstrb,
  output logic [TS_W-1:0]          rd_ts,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [15:0]              dropped
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [1:0] KIND_IFETCH = 2'd0;
  localparam logic [1:0] KIND_READ   = 2'd1;
  localparam logic [1:0] KIND_WRITE  = 2'd2;

  // Drop counter increment that holds at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Entry storage; contents are only meaningful between the pointers.
  logic [1:0]      kind_mem  [DEPTH];
  logic [31:0]     addr_mem  [DEPTH];
  logic [31:0]     data_mem  [DEPTH];
  logic [3:0]      wstrb_mem [DEPTH];
  logic [TS_W-1:0] ts_mem    [DEPTH];

  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     dropped_q, dropped_d;
  logic [TS_W-1:0] ts_q, ts_d;

  logic [1:0]      cls_kind;
  logic [31:0]     cls_data;
  logic [3:0]      cls_wstrb;
  logic            cls_en;
  logic            capture;
  logic            pop;
  logic            full;
  logic            wr_en;

  // Classify the current bus cycle and decide whether it is captured.
  always_comb begin
    cls_kind  = KIND_READ;
    cls_data  = mem_rdata;
    cls_wstrb = 4'b0000;
    if (mem_instr) begin
      cls_kind = KIND_IFETCH;
    end else if (mem_wstrb != 4'b0000) begin
      cls_kind  = KIND_WRITE;
      cls_data  = mem_wdata;
      cls_wstrb = mem_wstrb;
    end
    case (cls_kind)
      KIND_IFETCH: cls_en = cfg_en[0];
      KIND_READ:   cls_en = cfg_en[1];
      default:     cls_en = cfg_en[2];
    endcase
    capture = mem_valid && mem_ready && cls_en &&
              (mem_addr >= cfg_addr_lo) && (mem_addr <= cfg_addr_hi);
  end

  // Pointer, occupancy, overflow and timestamp next-state logic.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    dropped_d  = dropped_q;
    ts_d       = ts_q + TS_W'(1);
    wr_en      = 1'b0;
    pop        = rd_valid && rd_ready;
    full       = (count_q == FULL_CNT);
    if (cfg_clear) begin
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      dropped_d  = '0;
    end else begin
      if (pop) begin
        rptr_d = rptr_q + PW'(1);
      end
      if (capture) begin
        if (!full || pop) begin
          // A pop on a full buffer frees the slot the write lands in.
          wr_en  = 1'b1;
          wptr_d = wptr_q + PW'(1);
        end else begin
          overflow_d = 1'b1;
          dropped_d  = sat_inc16(dropped_q);
          if (WRAP != 0) begin
            // Full and wptr == rptr: replace the oldest, move head past it.
            wr_en  = 1'b1;
            wptr_d = wptr_q + PW'(1);
            rptr_d = rptr_q + PW'(1);
          end
        end
      end
      if (capture && !full && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !capture) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  // Control state register; reset overrides everything including clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      dropped_q  <= '0;
      ts_q       <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      dropped_q  <= dropped_d;
      ts_q       <= ts_d;
    end
  end

  // Entry write port; the timestamp stored is the one present at the capture edge.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      kind_mem[wptr_q]  <= cls_kind;
      addr_mem[wptr_q]  <= mem_addr;
      data_mem[wptr_q]  <= cls_data;
      wstrb_mem[wptr_q] <= cls_wstrb;
      ts_mem[wptr_q]    <= ts_q;
    end
  end

  // Head entry is shown only while valid so an empty buffer reads as zero.
  assign rd_valid = (count_q != '0);
  assign rd_kind  = rd_valid ? kind_mem[rptr_q]  : '0;
  assign rd_addr  = rd_valid ? addr_mem[rptr_q]  : '0;
  assign rd_data  = rd_valid ? data_mem[rptr_q]  : '0;
  assign rd_wstrb = rd_valid ? wstrb_mem[rptr_q] : '0;
  assign rd_ts    = rd_valid ? ts_mem[rptr_q]    : '0;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign dropped  = dropped_q;

endmodule
